mmul_sequencer: RTL and testbench

//  Top-level sequencer for one SYS_ARRAY_SIZE x SYS_ARRAY_SIZE systolic matrix-multiply.

---
 rtl/mmul_sequencer.sv | 153 +++++++++++++++
 tb/tb_mmul_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmul_sequencer.sv
// Command sequencer for one N x N systolic matrix multiply: feeds A/B rows,
// waits out the array skew, then optionally drains C rows to memory.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for a command; the only state with cmd_ready high
//   S_FEED  | issuing A/B row reads; each granted beat enters the array
//   S_FLUSH | fixed skew wait so the last partial sums settle; not stallable
//   S_DRAIN | writing C rows back; each wr_gnt completes one row
//   S_DONE  | single-cycle completion pulse
module mmul_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYS_ARRAY_SIZE = 2,
    parameter int ADDR_WIDTH     = 64,
    parameter int ROW_STRIDE     = SYS_ARRAY_SIZE * DATA_WIDTH / 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_drain,
    input  logic [ADDR_WIDTH-1:0]           cmd_a_addr,
    input  logic [ADDR_WIDTH-1:0]           cmd_b_addr,
    input  logic [ADDR_WIDTH-1:0]           cmd_c_addr,
    output logic                            rd_req,
    input  logic                            rd_gnt,
    output logic [ADDR_WIDTH-1:0]           rd_a_addr,
    output logic [ADDR_WIDTH-1:0]           rd_b_addr,
    output logic                            feed_valid,
    output logic [$clog2(SYS_ARRAY_SIZE)-1:0] feed_idx,
    output logic                            feed_last,
    output logic                            compute_en,
    output logic                            drain_en,
    input  logic                            wr_gnt,
    output logic [$clog2(SYS_ARRAY_SIZE)-1:0] drain_idx,
    output logic [ADDR_WIDTH-1:0]           wr_c_addr,
    output logic                            busy,
    output logic                            done
);

    localparam int T_C       = SYS_ARRAY_SIZE;
    localparam int T_D       = 2 * SYS_ARRAY_SIZE;
    localparam int FLUSH_CYC = T_D - 1;
    localparam int CW        = $clog2(T_C);
    localparam int FW        = $clog2(T_D);

    localparam logic [CW-1:0] IDX_LAST   = CW'(T_C - 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           idx, idx_nxt;
    logic [FW-1:0]           flush_cnt, flush_nxt;
    logic                    accept;
    logic                    drain_q;
    logic [ADDR_WIDTH-1:0]   a_base, b_base, c_base;
    logic [ADDR_WIDTH-1:0]   row_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            flush_cnt <= '0;
            drain_q   <= 1'b0;
            a_base    <= '0;
            b_base    <= '0;
            c_base    <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            flush_cnt <= flush_nxt;
            if (accept) begin
                drain_q <= cmd_drain;
                a_base  <= cmd_a_addr;
                b_base  <= cmd_b_addr;
                c_base  <= cmd_c_addr;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        flush_nxt = flush_cnt;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                if (rd_gnt) begin
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        flush_nxt = FLUSH_LOAD;
                        state_nxt = S_FLUSH;
                    end else begin
                        idx_nxt = idx + CW'(1);
                    end
                end
            end
            S_FLUSH: begin
                // Down-counter: loaded with FLUSH_CYC-1, exits on terminal count.
                if (flush_cnt == '0) begin
                    idx_nxt   = '0;
                    state_nxt = drain_q ? S_DRAIN : S_DONE;
                end else begin
                    flush_nxt = flush_cnt - FW'(1);
                end
            end
            S_DRAIN: begin
                if (wr_gnt) begin
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt = idx + CW'(1);
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Row offset wraps modulo 2^ADDR_WIDTH along with the base addition.
    assign row_off    = ADDR_WIDTH'(idx) * ADDR_WIDTH'(ROW_STRIDE);
    assign rd_a_addr  = a_base + row_off;
    assign rd_b_addr  = b_base + row_off;
    assign wr_c_addr  = c_base + row_off;

    assign cmd_ready  = (state == S_IDLE);
    assign rd_req     = (state == S_FEED);
    assign feed_valid = rd_req & rd_gnt;
    assign feed_last  = feed_valid & (idx == IDX_LAST);
    assign feed_idx   = (state == S_FEED) ? idx : '0;
    assign compute_en = (state == S_FEED) || (state == S_FLUSH);
    assign drain_en   = (state == S_DRAIN);
    assign drain_idx  = (state == S_DRAIN) ? idx : '0;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_mmul_sequencer.sv
// Directed bench for mmul_sequencer (N=2): cycle tables for the main flows
// plus hand-written sequences for reset, back-to-back commands and wrap/stall.
module tb_mmul_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_drain;
    logic [63:0] cmd_a_addr;
    logic [63:0] cmd_b_addr;
    logic [63:0] cmd_c_addr;
    logic        rd_req;
    logic        rd_gnt;
    logic [63:0] rd_a_addr;
    logic [63:0] rd_b_addr;
    logic        feed_valid;
    logic [0:0]  feed_idx;
    logic        feed_last;
    logic        compute_en;
    logic        drain_en;
    logic        wr_gnt;
    logic [0:0]  drain_idx;
    logic [63:0] wr_c_addr;
    logic        busy;
    logic        done;

    mmul_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_drain  (cmd_drain),
        .cmd_a_addr (cmd_a_addr),
        .cmd_b_addr (cmd_b_addr),
        .cmd_c_addr (cmd_c_addr),
        .rd_req     (rd_req),
        .rd_gnt     (rd_gnt),
        .rd_a_addr  (rd_a_addr),
        .rd_b_addr  (rd_b_addr),
        .feed_valid (feed_valid),
        .feed_idx   (feed_idx),
        .feed_last  (feed_last),
        .compute_en (compute_en),
        .drain_en   (drain_en),
        .wr_gnt     (wr_gnt),
        .drain_idx  (drain_idx),
        .wr_c_addr  (wr_c_addr),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag order: ready, rd_req, feed_valid, feed_last, feed_idx,
    //             compute_en, drain_en, drain_idx, busy, done
    localparam logic [9:0] P_IDLE  = 10'b1_0_0_0_0_0_0_0_0_0;
    localparam logic [9:0] P_FEED0 = 10'b0_1_1_0_0_1_0_0_1_0;
    localparam logic [9:0] P_STALL = 10'b0_1_0_0_0_1_0_0_1_0;
    localparam logic [9:0] P_FEED1 = 10'b0_1_1_1_1_1_0_0_1_0;
    localparam logic [9:0] P_FLUSH = 10'b0_0_0_0_0_1_0_0_1_0;
    localparam logic [9:0] P_DRN0  = 10'b0_0_0_0_0_0_1_0_1_0;
    localparam logic [9:0] P_DRN1  = 10'b0_0_0_0_0_0_1_1_1_0;
    localparam logic [9:0] P_DONE  = 10'b0_0_0_0_0_0_0_0_1_1;

    typedef struct {
        logic        cv;
        logic        drn;
        logic        rg;
        logic        wg;
        logic [9:0]  exp;
        logic        chk;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] ec;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    function automatic logic [9:0] flags();
        return {cmd_ready, rd_req, feed_valid, feed_last, feed_idx,
                compute_en, drain_en, drain_idx, busy, done};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic cv, input logic drn, input logic rg, input logic wg,
                       input logic [9:0] exp, input logic chk,
                       input logic [63:0] ea, input logic [63:0] eb, input logic [63:0] ec);
        vec_t v;
        v.cv = cv; v.drn = drn; v.rg = rg; v.wg = wg;
        v.exp = exp; v.chk = chk; v.ea = ea; v.eb = eb; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic add_row0(input logic cv, input logic drn, input logic rg, input logic [9:0] exp);
        add(cv, drn, rg, 1'b1, exp, 1'b1, 64'h100, 64'h200, 64'h300);
    endtask

    task automatic add_row1(input logic [9:0] exp);
        add(1'b0, 1'b0, 1'b1, 1'b1, exp, 1'b1, 64'h102, 64'h202, 64'h302);
    endtask

    int done_seen;
    int accepts, dones;
    int acc_cyc[2];
    int done_cyc[2];
    bit drop_cv;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_drain = 1'b0;
        cmd_a_addr = 64'h100;
        cmd_b_addr = 64'h200;
        cmd_c_addr = 64'h300;
        rd_gnt = 1'b1;
        wr_gnt = 1'b1;

        #2 rst = 1'b1;
        #1;
        check("reset_flags", 64'(flags()), 64'(P_IDLE));
        check("reset_addr", rd_a_addr | rd_b_addr | wr_c_addr, 64'h0);
        step();
        rst = 1'b0;

        // Reset mid-DRAIN abandons the operation without a done pulse.
        cmd_valid = 1'b1;
        cmd_drain = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (5) step();
        check("pre_reset_drain", 64'(flags()), 64'(P_DRN0));
        #2 rst = 1'b1;
        #1;
        check("mid_drain_reset_flags", 64'(flags()), 64'(P_IDLE));
        check("mid_drain_reset_a", rd_a_addr, 64'h0);
        check("mid_drain_reset_c", wr_c_addr, 64'h0);
        step();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_seen++;
            step();
        end
        check("no_done_after_reset", 64'(done_seen), 64'h0);
        check("idle_after_reset", 64'(flags()), 64'(P_IDLE));

        // MMUL_D, gnts high: done appears 7 edges after the accepting edge.
        add(1'b1, 1'b1, 1'b1, 1'b1, P_IDLE, 1'b0, 64'h0, 64'h0, 64'h0);
        add_row0(1'b0, 1'b0, 1'b1, P_FEED0);
        add_row1(P_FEED1);
        add_row0(1'b0, 1'b0, 1'b1, P_FLUSH);
        add_row0(1'b0, 1'b0, 1'b1, P_FLUSH);
        add_row0(1'b0, 1'b0, 1'b1, P_FLUSH);
        add_row0(1'b0, 1'b0, 1'b1, P_DRN0);
        add_row1(P_DRN1);
        add_row0(1'b0, 1'b0, 1'b1, P_DONE);
        add(1'b0, 1'b0, 1'b1, 1'b1, P_IDLE, 1'b0, 64'h0, 64'h0, 64'h0);
        // MMUL_ND: no drain, done 5 edges after accept.
        add(1'b1, 1'b0, 1'b1, 1'b1, P_IDLE, 1'b0, 64'h0, 64'h0, 64'h0);
        add_row0(1'b0, 1'b0, 1'b1, P_FEED0);
        add_row1(P_FEED1);
        add_row0(1'b0, 1'b0, 1'b1, P_FLUSH);
        add_row0(1'b0, 1'b0, 1'b1, P_FLUSH);
        add_row0(1'b0, 1'b0, 1'b1, P_FLUSH);
        add_row0(1'b0, 1'b0, 1'b1, P_DONE);
        add(1'b0, 1'b0, 1'b1, 1'b1, P_IDLE, 1'b0, 64'h0, 64'h0, 64'h0);
        // MMUL_ND with rd_gnt low for 3 cycles on beat 0: done 3 edges later.
        add(1'b1, 1'b0, 1'b1, 1'b1, P_IDLE, 1'b0, 64'h0, 64'h0, 64'h0);
        add_row0(1'b0, 1'b0, 1'b0, P_STALL);
        add_row0(1'b0, 1'b0, 1'b0, P_STALL);
        add_row0(1'b0, 1'b0, 1'b0, P_STALL);
        add_row0(1'b0, 1'b0, 1'b1, P_FEED0);
        add_row1(P_FEED1);
        add_row0(1'b0, 1'b0, 1'b1, P_FLUSH);
        add_row0(1'b0, 1'b0, 1'b1, P_FLUSH);
        add_row0(1'b0, 1'b0, 1'b1, P_FLUSH);
        add_row0(1'b0, 1'b0, 1'b1, P_DONE);
        add(1'b0, 1'b0, 1'b1, 1'b1, P_IDLE, 1'b0, 64'h0, 64'h0, 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            cmd_valid = vecs[i].cv;
            cmd_drain = vecs[i].drn;
            rd_gnt    = vecs[i].rg;
            wr_gnt    = vecs[i].wg;
            #1;
            check($sformatf("vec%0d_flags", i), 64'(flags()), 64'(vecs[i].exp));
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_a", i), rd_a_addr, vecs[i].ea);
                check($sformatf("vec%0d_b", i), rd_b_addr, vecs[i].eb);
                check($sformatf("vec%0d_c", i), wr_c_addr, vecs[i].ec);
            end
            step();
        end
        cmd_valid = 1'b0;
        rd_gnt = 1'b1;
        wr_gnt = 1'b1;

        // cmd_valid held high: second op accepted only the cycle after done.
        accepts = 0;
        dones = 0;
        acc_cyc[0] = -1; acc_cyc[1] = -1;
        done_cyc[0] = -1; done_cyc[1] = -1;
        drop_cv = 1'b0;
        cmd_valid = 1'b1;
        cmd_drain = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cmd_valid && cmd_ready) begin
                if (accepts < 2) acc_cyc[accepts] = cyc;
                accepts++;
                if (accepts == 2) drop_cv = 1'b1;
            end
            if (done) begin
                if (dones < 2) done_cyc[dones] = cyc;
                dones++;
            end
            step();
            if (drop_cv) cmd_valid = 1'b0;
        end
        check("b2b_accepts", 64'(accepts), 64'd2);
        check("b2b_dones", 64'(dones), 64'd2);
        check("b2b_first_done", 64'(done_cyc[0]), 64'd8);
        check("b2b_second_accept", 64'(acc_cyc[1]), 64'd9);
        check("b2b_second_done", 64'(done_cyc[1]), 64'd17);

        // Address wrap on A and wr_gnt stalls during drain.
        cmd_a_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        cmd_b_addr = 64'h40;
        cmd_c_addr = 64'h10;
        cmd_valid = 1'b1;
        cmd_drain = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("wrap_beat0_a", rd_a_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        wr_gnt = 1'b0;
        check("wrap_beat1_a", rd_a_addr, 64'h1);
        check("wrap_beat1_b", rd_b_addr, 64'h42);
        check("wrap_beat1_last", 64'(feed_last), 64'h1);
        repeat (4) step();
        check("stall_drain0_flags", 64'(flags()), 64'(P_DRN0));
        step();
        check("stall_hold_flags", 64'(flags()), 64'(P_DRN0));
        check("stall_hold_c", wr_c_addr, 64'h10);
        step();
        check("stall_hold2_flags", 64'(flags()), 64'(P_DRN0));
        wr_gnt = 1'b1;
        step();
        check("stall_drain1_flags", 64'(flags()), 64'(P_DRN1));
        check("stall_drain1_c", wr_c_addr, 64'h12);
        step();
        check("stall_done", 64'(flags()), 64'(P_DONE));
        step();
        check("stall_idle", 64'(flags()), 64'(P_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
